// File: rtl/score_keeper.sv
// score_keeper: goal detection, score keeping and match sequencing for the
// pong datapath. Watches the ball position from the ball-motion stage, counts
// goals on rising edges of the edge condition, and gates the ball via ball_run.
// Optional feature macro: AUTO_RESTART_EN (GAME_OVER times out back to IDLE).
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | waiting for start; ball held, scores hold
// SERVE      | post-start / post-goal pause, counter runs down on frame_tick
// PLAY       | ball free-running, goals counted
// GAME_OVER  | a player reached WIN_SCORE; winner and scores hold

module score_keeper #(
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_DELAY = 60,
  parameter int LEFT_GOAL   = 2,
  parameter int RIGHT_GOAL  = 635,
  parameter int OVER_DELAY  = 180
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  output logic       ball_run,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic       scored_pulse,
  output logic       last_scorer,
  output logic       game_over,
  output logic [1:0] winner
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SERVE     = 2'd1,
    PLAY      = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  localparam logic [9:0] LEFT_V  = 10'(LEFT_GOAL);
  localparam logic [9:0] RIGHT_V = 10'(RIGHT_GOAL);
  localparam logic [9:0] Y_LIMIT = 10'd480;
  localparam logic [3:0] WIN_V   = 4'(WIN_SCORE);
  localparam logic [7:0] SERVE_V = 8'(SERVE_DELAY);
  localparam logic [7:0] OVER_V  = 8'(OVER_DELAY);

  state_t     state;
  logic [7:0] counter;
  logic       prev_gl;
  logic       prev_gr;

  logic       gl;
  logic       gr;
  logic       goal_l;
  logic       goal_r;
  logic [3:0] p1_inc;
  logic [3:0] p2_inc;

  // Edge conditions, rising-edge goal qualification (left wins a tie) and
  // saturating score increments.
  always_comb begin
    gl     = (ball_x < LEFT_V) && (ball_y < Y_LIMIT);
    gr     = (ball_x >= RIGHT_V) && (ball_y < Y_LIMIT);
    goal_l = gl && !prev_gl;
    goal_r = gr && !prev_gr && !gl;
    p1_inc = (p1_score == 4'd15) ? 4'd15 : p1_score + 4'd1;
    p2_inc = (p2_score == 4'd15) ? 4'd15 : p2_score + 4'd1;
  end

  // Match state machine with all outputs registered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      counter      <= 8'd0;
      prev_gl      <= 1'b0;
      prev_gr      <= 1'b0;
      ball_run     <= 1'b0;
      p1_score     <= 4'd0;
      p2_score     <= 4'd0;
      scored_pulse <= 1'b0;
      last_scorer  <= 1'b0;
      game_over    <= 1'b0;
      winner       <= 2'b00;
    end else begin
      prev_gl      <= gl;
      prev_gr      <= gr;
      scored_pulse <= 1'b0;
      case (state)
        IDLE: begin
          ball_run <= 1'b0;
          if (start) begin
            p1_score <= 4'd0;
            p2_score <= 4'd0;
            winner   <= 2'b00;
            counter  <= SERVE_V;
            state    <= SERVE;
          end
        end
        SERVE: begin
          if (frame_tick) begin
            if (counter <= 8'd1) begin
              counter  <= 8'd0;
              ball_run <= 1'b1;
              state    <= PLAY;
            end else begin
              counter <= counter - 8'd1;
            end
          end
        end
        PLAY: begin
          if (goal_l || goal_r) begin
            scored_pulse <= 1'b1;
            ball_run     <= 1'b0;
            last_scorer  <= goal_l;
            if (goal_l) p2_score <= p2_inc;
            else        p1_score <= p1_inc;
            if ((goal_l && p2_inc == WIN_V) || (goal_r && p1_inc == WIN_V)) begin
              // OVER_DELAY load is only consumed by the auto-restart timeout.
              counter   <= OVER_V;
              game_over <= 1'b1;
              winner    <= goal_l ? 2'b10 : 2'b01;
              state     <= GAME_OVER;
            end else begin
              counter <= SERVE_V;
              state   <= SERVE;
            end
          end
        end
        GAME_OVER: begin
          ball_run <= 1'b0;
`ifdef AUTO_RESTART_EN
          if (start || (frame_tick && counter <= 8'd1)) begin
            counter   <= 8'd0;
            p1_score  <= 4'd0;
            p2_score  <= 4'd0;
            winner    <= 2'b00;
            game_over <= 1'b0;
            state     <= IDLE;
          end else if (frame_tick) begin
            counter <= counter - 8'd1;
          end
`else
          if (start) begin
            p1_score  <= 4'd0;
            p2_score  <= 4'd0;
            winner    <= 2'b00;
            game_over <= 1'b0;
            counter   <= SERVE_V;
            state     <= SERVE;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with WIN_SCORE=3, SERVE_DELAY=3,
// OVER_DELAY=2. Expected outputs packed as
// {ball_run, p1_score, p2_score, scored_pulse, last_scorer, game_over, winner}.

module tb_score_keeper;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic [9:0] ball_x = 10'd320;
  logic [9:0] ball_y = 10'd240;
  logic       ball_run;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic       scored_pulse;
  logic       last_scorer;
  logic       game_over;
  logic [1:0] winner;

  int checks = 0;
  int errors = 0;

  score_keeper #(
    .WIN_SCORE(3), .SERVE_DELAY(3), .LEFT_GOAL(2), .RIGHT_GOAL(635), .OVER_DELAY(2)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
    .ball_x(ball_x), .ball_y(ball_y), .ball_run(ball_run),
    .p1_score(p1_score), .p2_score(p2_score), .scored_pulse(scored_pulse),
    .last_scorer(last_scorer), .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        st;
    logic        tk;
    logic [9:0]  bx;
    logic [9:0]  by;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [13:0] o(input logic run, input logic [3:0] p1,
                                    input logic [3:0] p2, input logic pu,
                                    input logic la, input logic go,
                                    input logic [1:0] wi);
    return {run, p1, p2, pu, la, go, wi};
  endfunction

  task automatic add(input logic rst, input logic st, input logic tk,
                     input logic [9:0] bx, input logic [9:0] by,
                     input logic [13:0] exp);
    vec_t v;
    v.rst = rst; v.st = st; v.tk = tk; v.bx = bx; v.by = by; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic step(input logic rst, input logic st, input logic tk,
                      input logic [9:0] bx, input logic [9:0] by);
    reset = rst; start = st; frame_tick = tk; ball_x = bx; ball_y = by;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [13:0] exp);
    logic [13:0] act;
    act = {ball_run, p1_score, p2_score, scored_pulse, last_scorer, game_over, winner};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got run=%b p1=%0d p2=%0d pulse=%b last=%b go=%b win=%b, expected run=%b p1=%0d p2=%0d pulse=%b last=%b go=%b win=%b",
               name, act[13], act[12:9], act[8:5], act[4], act[3], act[2], act[1:0],
               exp[13], exp[12:9], exp[8:5], exp[4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  task automatic serve3(input logic [9:0] bx);
    step(1, 0, 1, bx, 240);
    step(1, 0, 1, bx, 240);
    step(1, 0, 1, bx, 240);
  endtask

  initial begin
    // Reset and idle hold
    step(0, 0, 0, 320, 240);
    step(0, 0, 0, 320, 240);
    chk("reset", o(0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 100; i++) begin
      step(1, 0, 0, 320, 240);
      chk("idle_hold", o(0, 0, 0, 0, 0, 0, 0));
    end

    // Cycle-by-cycle match vectors
    add(0, 0, 0, 320, 240, o(0, 0, 0, 0, 0, 0, 0));
    add(1, 0, 0, 320, 240, o(0, 0, 0, 0, 0, 0, 0));
    add(1, 1, 0, 320, 240, o(0, 0, 0, 0, 0, 0, 0));
    add(1, 1, 0, 320, 240, o(0, 0, 0, 0, 0, 0, 0));
    add(1, 0, 1, 320, 240, o(0, 0, 0, 0, 0, 0, 0));
    add(1, 0, 0, 320, 240, o(0, 0, 0, 0, 0, 0, 0));
    add(1, 0, 1, 320, 240, o(0, 0, 0, 0, 0, 0, 0));
    add(1, 0, 1, 320, 240, o(1, 0, 0, 0, 0, 0, 0));
    add(1, 0, 0,   5, 240, o(1, 0, 0, 0, 0, 0, 0));
    add(1, 0, 0,   1, 240, o(0, 0, 1, 1, 1, 0, 0));
    add(1, 0, 0,   1, 240, o(0, 0, 1, 0, 1, 0, 0));
    add(1, 0, 1,   1, 240, o(0, 0, 1, 0, 1, 0, 0));
    add(1, 0, 1,   1, 240, o(0, 0, 1, 0, 1, 0, 0));
    add(1, 0, 1,   1, 240, o(1, 0, 1, 0, 1, 0, 0));
    add(1, 0, 0,   1, 240, o(1, 0, 1, 0, 1, 0, 0));
    add(1, 0, 0, 634, 240, o(1, 0, 1, 0, 1, 0, 0));
    add(1, 0, 0, 635, 240, o(0, 1, 1, 1, 0, 0, 0));
    add(1, 0, 1, 635, 240, o(0, 1, 1, 0, 0, 0, 0));
    add(1, 0, 1, 635, 240, o(0, 1, 1, 0, 0, 0, 0));
    add(1, 0, 1, 634, 240, o(1, 1, 1, 0, 0, 0, 0));
    add(1, 0, 1, 635, 240, o(0, 2, 1, 1, 0, 0, 0));
    add(1, 0, 1, 634, 240, o(0, 2, 1, 0, 0, 0, 0));
    add(1, 0, 1, 634, 240, o(0, 2, 1, 0, 0, 0, 0));
    add(1, 0, 1, 634, 240, o(1, 2, 1, 0, 0, 0, 0));
    add(1, 0, 0, 635, 480, o(1, 2, 1, 0, 0, 0, 0));
    add(1, 0, 0, 635, 240, o(0, 3, 1, 1, 0, 1, 2'b01));
    add(1, 0, 0, 634, 240, o(0, 3, 1, 0, 0, 1, 2'b01));
    add(1, 0, 0, 635, 240, o(0, 3, 1, 0, 0, 1, 2'b01));
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].st, vecs[i].tk, vecs[i].bx, vecs[i].by);
      chk($sformatf("vec%0d", i), vecs[i].exp);
    end

    // GAME_OVER exit
`ifdef AUTO_RESTART_EN
    step(1, 0, 1, 634, 240);
    chk("over_tick1", o(0, 3, 1, 0, 0, 1, 2'b01));
    step(1, 0, 1, 634, 240);
    chk("over_timeout_idle", o(0, 0, 0, 0, 0, 0, 0));
    step(1, 0, 0, 634, 240);
    chk("idle_after_timeout", o(0, 0, 0, 0, 0, 0, 0));
    step(1, 1, 0, 634, 240);
`else
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 634, 240);
      chk("over_hold", o(0, 3, 1, 0, 0, 1, 2'b01));
    end
    step(1, 1, 0, 634, 240);
`endif
    chk("restart_serve", o(0, 0, 0, 0, 0, 0, 0));
    serve3(634);
    chk("restart_play", o(1, 0, 0, 0, 0, 0, 0));

    // Reset mid-PLAY with p1_score=2
    step(1, 0, 0, 635, 240);
    chk("mid_goal1", o(0, 1, 0, 1, 0, 0, 0));
    serve3(634);
    chk("mid_play1", o(1, 1, 0, 0, 0, 0, 0));
    step(1, 0, 0, 635, 240);
    chk("mid_goal2", o(0, 2, 0, 1, 0, 0, 0));
    serve3(634);
    chk("mid_play2", o(1, 2, 0, 0, 0, 0, 0));
    step(0, 0, 0, 635, 240);
    chk("mid_reset", o(0, 0, 0, 0, 0, 0, 0));
    step(1, 0, 1, 634, 240);
    chk("post_reset_idle", o(0, 0, 0, 0, 0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
Sits directly downstream of the ball-motion stage. It watches the ball position that stage produces, detects goals at the left and right field edges, and keeps both player scores. It runs the match state machine: idle, play, post-goal serve pause, and game over. It drives ball_run, which gates the ball-motion stage, and provides scores and winner to the display/score renderer.

Parameters:
WIN_SCORE, 7, points needed to win; legal range 1..15
SERVE_DELAY, 60, frame_ticks the ball is held after a goal before play resumes; legal range 1..255
LEFT_GOAL, 2, ball_x strictly below this value = goal for P2
RIGHT_GOAL, 635, ball_x at or above this value = goal for P1
OVER_DELAY, 180, frame_ticks spent in GAME_OVER before auto-restart (used only with AUTO_RESTART_EN); legal range 1..255

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
frame_tick  in  1  one-cycle pulse per video frame
start  in  1  start button, already debounced, level
ball_x  in  10  ball x position from the ball-motion stage
ball_y  in  10  ball y position (only used for goal qualification: must be < 480)
ball_run  out  1  high = ball-motion stage may advance; low = hold/recentre
p1_score  out  4  P1 points, binary
p2_score  out  4  P2 points, binary
scored_pulse  out  1  one-cycle pulse on each counted goal
last_scorer  out  1  0 = P1, 1 = P2 scored most recently
game_over  out  1  high while in GAME_OVER
winner  out  2  00 none, 01 P1, 10 P2; 11 never driven

Behaviour:
- Reset (reset==0 at posedge clk): state IDLE; all outputs 0; scores 0; delay counter 0; goal-edge register 0.
- Goal condition (combinational): gl = (ball_x < LEFT_GOAL) & (ball_y < 480); gr = (ball_x >= RIGHT_GOAL) & (ball_y < 480).
- Goal detection:
  - gl and gr are registered each clk into prev_gl and prev_gr.
  - A goal counts only on a rising edge (cond & ~prev) and only in PLAY.
  - A ball held at the edge therefore scores once.
  - gl and gr cannot be true together with legal parameters; if both are, gl wins.
- States:
  - IDLE:
    - ball_run=0, scores hold.
    - start==1 → clear scores, winner=00, go to SERVE with counter=SERVE_DELAY.
  - SERVE:
    - ball_run=0.
    - Counter decrements on frame_tick.
    - On a frame_tick with counter==1 → PLAY (counter 0).
  - PLAY:
    - ball_run=1.
    - Left goal → p2_score+1, last_scorer=1.
    - Right goal → p1_score+1, last_scorer=0.
    - Both cases: scored_pulse=1 for one cycle, registered.
    - Next state: if the new score == WIN_SCORE → GAME_OVER with winner set; else SERVE with counter=SERVE_DELAY.
    - Score, state and pulse all update on the same clk edge as the detected edge (latency 1 clk from the ball_x change).
  - GAME_OVER:
    - ball_run=0, game_over=1; winner and scores hold.
    - Exit is governed by the optional feature.
- Scores saturate at 15 and are never incremented outside PLAY.
- start is ignored in SERVE and PLAY; start held through IDLE→SERVE has no further effect.
- frame_tick and a goal in the same cycle: the goal is processed; the tick is irrelevant in PLAY.
- Reset asserted mid-game: immediate return to IDLE with everything cleared on that edge.

Optional Feature:
AUTO_RESTART_EN
- Defined: on entry to GAME_OVER, counter=OVER_DELAY. It decrements on frame_tick; at 1 → IDLE, with scores and winner cleared on IDLE entry (attract loop). A start==1 in GAME_OVER also goes straight to IDLE.
- Undefined: GAME_OVER is left only by start==1, which goes to SERVE with scores cleared and counter=SERVE_DELAY. OVER_DELAY is unused.

Test Plan:
1. Reset low 2 clks, then high with start=0 → state IDLE, ball_run=0, p1_score=p2_score=0, winner=00 for 100 clks.
2. start=1 for 1 clk, SERVE_DELAY=3, frame_tick every 10 clks → ball_run rises on the clk after the 3rd tick.
3. In PLAY, step ball_x 5→1 and hold at 1 for 20 clks → p2_score=1 exactly once, one scored_pulse, last_scorer=1, ball_run=0 (SERVE).
4. Repeated right goals (ball_x 634→635) with WIN_SCORE=3 → p1_score reaches 3, game_over=1, winner=01, and further edge crossings do not change scores.
5. Reset low mid-PLAY with p1_score=2 → next clk: IDLE, scores 0, scored_pulse 0.
6. With AUTO_RESTART_EN, OVER_DELAY=2 → IDLE after 2 ticks with scores cleared. Without it → remains in GAME_OVER until start, then SERVE.
